hue_stage0: RTL

HUE_STAGE0 -- requirements
Module: hue_stage0

---
 rtl/hue_pkg.sv | 8 +
 rtl/hue_stage0_rgb_maxmin.sv | 17 +
 rtl/hue_stage0.sv | 60 ++++++
 3 files changed

// File: rtl/hue_pkg.sv
// hue_pkg: shared channel width, function codes and RGB565 channel expansion for the hue pipeline
package hue_pkg;
  localparam int CH_W = 6;
  typedef enum logic [1:0] {FN_NONE = 2'd0, FN_R = 2'd1, FN_G = 2'd2, FN_B = 2'd3} fn_e;
  function automatic logic [CH_W-1:0] exp5(input logic [4:0] c);
    return {c, c[4]};
  endfunction
endpackage

// File: rtl/hue_stage0_rgb_maxmin.sv
// rgb_maxmin: combinational max, min and argmax (R over G over B on ties) of three channels
module rgb_maxmin
  import hue_pkg::*;
(
  input  logic [CH_W-1:0] r,
  input  logic [CH_W-1:0] g,
  input  logic [CH_W-1:0] b,
  output logic [CH_W-1:0] mx,
  output logic [CH_W-1:0] mn,
  output fn_e             arg
);
  always_comb begin
    arg = (r >= g && r >= b) ? FN_R : (g >= b) ? FN_G : FN_B;
    mx  = (arg == FN_R) ? r : (arg == FN_G) ? g : b;
    mn  = (r <= g && r <= b) ? r : (g <= b) ? g : b;
  end
endmodule

// File: rtl/hue_stage0.sv
// hue_stage0: two-stage RGB565 front end producing hue numerator, max-channel code and delta
module hue_stage0
  import hue_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [15:0]      i_data,
  input  logic             i_valid,
  output logic [OUT_W-1:0] o_data,
  output logic [1:0]       o_function,
  output logic [CH_W-1:0]  o_delta,
  output logic             o_valid
);
  logic [CH_W-1:0] r_a, g_a, b_a, mx, mn;
  logic            v_a;
  fn_e             arg, fn;
  logic [CH_W:0]   num;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_a <= '0;
      g_a <= '0;
      b_a <= '0;
      v_a <= 1'b0;
    end else begin
      r_a <= exp5(i_data[15:11]);
      g_a <= i_data[10:5];
      b_a <= exp5(i_data[4:0]);
      v_a <= i_valid;
    end
  end
  rgb_maxmin u_mm (
    .r  (r_a),
    .g  (g_a),
    .b  (b_a),
    .mx (mx),
    .mn (mn),
    .arg(arg)
  );
  always_comb begin
    fn  = (mx == mn) ? FN_NONE : arg;
    num = (fn == FN_R) ? {1'b0, g_a} - {1'b0, b_a} :
          (fn == FN_G) ? {1'b0, b_a} - {1'b0, r_a} :
          (fn == FN_B) ? {1'b0, r_a} - {1'b0, g_a} : '0;
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_data     <= '0;
      o_function <= '0;
      o_delta    <= '0;
      o_valid    <= 1'b0;
    end else begin
      o_data     <= v_a ? OUT_W'($signed(num)) : '0;
      o_function <= v_a ? fn : FN_NONE;
      o_delta    <= v_a ? mx - mn : '0;
      o_valid    <= v_a;
    end
  end
endmodule
